// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state enum, round-count constants and the
// GF(2^8) inverse-round building blocks used by the round core.
package aes_pkg;

  localparam int BLOCK_W   = 128;
  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } ctrl_state_e;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] y;
    y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return ginv(y);
  endfunction

  // Byte i of the block lives at [127-8i -: 8]; byte 4c+r is row r, column c.
  function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_sub_bytes(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] add_round_key(input logic [BLOCK_W-1:0] s,
                                                       input logic [BLOCK_W-1:0] k);
    return s ^ k;
  endfunction

  localparam logic [31:0] IMC_COEF = 32'h0e0b0d09;

  function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    logic [7:0]         acc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(s[127-8*(4*c+k) -: 8], IMC_COEF[31-8*((k-r+4)%4) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

endpackage

// File: rtl/inv_round_core.sv
// Combinational AES inverse round; final_rnd skips InvMixColumns for the last round.
module inv_round_core
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] blk_in,
  input  logic [BLOCK_W-1:0] round_key,
  input  logic               final_rnd,
  output logic [BLOCK_W-1:0] blk_out
);

  logic [BLOCK_W-1:0] keyed;

  assign keyed   = add_round_key(inv_sub_bytes(inv_shift_rows(blk_in)), round_key);
  assign blk_out = final_rnd ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/inv_cipher_ctrl.sv
// Iterative AES inverse-cipher sequencer: one round per clock, round keys read Nr down to 0.
// Optional abort input is enabled by defining INV_CIPHER_CTRL_ABORT_EN.
//   state | meaning
//   IDLE  | waiting for ciphertext; the accept cycle issues the key-Nr read
//   INIT  | initial AddRoundKey with key Nr
//   ROUND | full inverse rounds using keys Nr-1 .. 1
//   FINAL | last round without InvMixColumns, key 0
//   DONE  | plaintext presented until out_ready
module inv_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int Nk   = 4,
  parameter int Nr   = 10,
  parameter int IDXW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               rk_rd_en,
  output logic [IDXW-1:0]    rk_idx,
  input  logic [BLOCK_W-1:0] rk_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
`ifdef INV_CIPHER_CTRL_ABORT_EN
  ,
  input  logic               abort
`endif
);

  // Key length is authoritative; an inconsistent Nr falls back to Nk+6.
  localparam int              NR_EFF = (Nr == nr_of(Nk)) ? Nr : nr_of(Nk);
  localparam logic [IDXW-1:0] NR_IDX = IDXW'(NR_EFF);

  ctrl_state_e        st_q, st_d;
  logic [BLOCK_W-1:0] blk_q, blk_d, core_out;
  logic [IDXW-1:0]    cnt_q, cnt_d;
  logic               accept, is_final;

`ifdef INV_CIPHER_CTRL_ABORT_EN
  assign in_ready = (st_q == ST_IDLE) && !rst && !abort;
`else
  assign in_ready = (st_q == ST_IDLE) && !rst;
`endif
  assign accept    = in_valid && in_ready;
  assign out_valid = (st_q == ST_DONE);
  assign busy      = (st_q != ST_IDLE);
  assign out_data  = blk_q;
  assign is_final  = (st_q == ST_FINAL);

  inv_round_core u_core (
    .blk_in    (blk_q),
    .round_key (rk_data),
    .final_rnd (is_final),
    .blk_out   (core_out)
  );

  always_comb begin
    st_d     = st_q;
    blk_d    = blk_q;
    cnt_d    = cnt_q;
    rk_rd_en = 1'b0;
    rk_idx   = '0;
    case (st_q)
      ST_IDLE: begin
        if (accept) begin
          blk_d    = in_data;
          rk_rd_en = 1'b1;
          rk_idx   = NR_IDX;
          st_d     = ST_INIT;
        end
      end
      ST_INIT: begin
        blk_d    = blk_q ^ rk_data;
        rk_rd_en = 1'b1;
        rk_idx   = NR_IDX - 1'b1;
        cnt_d    = NR_IDX - 1'b1;
        st_d     = ST_ROUND;
      end
      ST_ROUND: begin
        blk_d    = core_out;
        rk_rd_en = 1'b1;
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - 1'b1;
          rk_idx = cnt_q - 1'b1;
        end
        if (cnt_q <= IDXW'(1)) st_d = ST_FINAL;
      end
      ST_FINAL: begin
        blk_d = core_out;
        st_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
`ifdef INV_CIPHER_CTRL_ABORT_EN
    // Abort drops the block but leaves the partially processed data in place.
    if (abort && st_q != ST_IDLE) begin
      st_d  = ST_IDLE;
      blk_d = blk_q;
      cnt_d = cnt_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ST_IDLE;
      blk_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      blk_q <= blk_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Bench for inv_cipher_ctrl: AES-128 and AES-256 instances checked against a forward-cipher model.
// Abort checks are included when INV_CIPHER_CTRL_ABORT_EN is defined.
module tb_inv_cipher_ctrl;

  localparam int NU  = 2;
  localparam int NR0 = 10;
  localparam int NR1 = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [NU];
  logic         in_ready  [NU];
  logic [127:0] in_data   [NU];
  logic         rk_rd_en  [NU];
  logic [3:0]   rk_idx    [NU];
  logic [127:0] rk_data   [NU];
  logic         out_valid [NU];
  logic         out_ready [NU];
  logic [127:0] out_data  [NU];
  logic         busy      [NU];
`ifdef INV_CIPHER_CTRL_ABORT_EN
  logic         abort_s   [NU];
`endif

  logic [127:0] rks [NU][16];
  logic [7:0]   sbox [256];
  int           idx_log [$];
  int           cyc = 0;
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rk_rd_en[0] === 1'b1) idx_log.push_back(int'(rk_idx[0]));

  for (genvar g = 0; g < NU; g++) begin : g_dut
    localparam int NKG = (g == 0) ? 4 : 8;
    inv_cipher_ctrl #(.Nk(NKG), .Nr(NKG + 6), .IDXW(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .rk_rd_en  (rk_rd_en[g]),
      .rk_idx    (rk_idx[g]),
      .rk_data   (rk_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
`ifdef INV_CIPHER_CTRL_ABORT_EN
      ,
      .abort     (abort_s[g])
`endif
    );
    // Synchronous key store; garbage when not read so late/early use is visible.
    always @(posedge clk) begin
      if (rk_rd_en[g] === 1'b1) rk_data[g] <= rks[g][rk_idx[g]];
      else                      rk_data[g] <= {$urandom, $urandom, $urandom, $urandom};
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: forward AES with polynomial-reduction GF multiply.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] sb_calc(input logic [7:0] x);
    logic [7:0] v;
    v = '0;
    for (int y = 1; y < 256; y++) if (gm(x, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic load_keys(input int u, input int nk, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gm(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) rks[u][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input int u, input logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0]   a [4];
    int           nr;
    nr = (u == 0) ? NR0 : NR1;
    s  = pt ^ rks[u][0];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[127-8*(4*c+r) -: 8] = sbox[s[127-8*(4*((c+r)%4)+r) -: 8]];
      if (rd < nr)
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = t[127-8*(4*c+r) -: 8];
          for (int r = 0; r < 4; r++)
            t[127-8*(4*c+r) -: 8] = gm(a[r] ^ a[(r+1)%4], 8'h02) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
      s = t ^ rks[u][rd];
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start(input int u, input logic [127:0] ct, input string tag);
    int k;
    in_data[u]  = ct;
    in_valid[u] = 1'b1;
    k = 0;
    while (in_ready[u] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    chk1({tag, " accept"}, in_ready[u], 1'b1);
    @(negedge clk);
    in_valid[u] = 1'b0;
    in_data[u]  = ~ct;
    chk1({tag, " busy"}, busy[u], 1'b1);
  endtask

  task automatic xfer(input int u, input logic [127:0] ct, input logic [127:0] pt,
                      input int stall, input string tag);
    int           k;
    logic [127:0] held;
    out_ready[u] = (stall == 0);
    start(u, ct, tag);
    k = 1;
    while (out_valid[u] !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    chki({tag, " latency"}, k, ((u == 0) ? NR0 : NR1) + 2);
    chkw({tag, " data"}, out_data[u], pt);
    held = pt;
    repeat (stall) begin
      @(negedge clk);
      chk1({tag, " stall valid"}, out_valid[u], 1'b1);
      chkw({tag, " stall data"}, out_data[u], held);
      chk1({tag, " stall in_ready"}, in_ready[u], 1'b0);
      chk1({tag, " stall busy"}, busy[u], 1'b1);
      chk1({tag, " stall rd_en"}, rk_rd_en[u], 1'b0);
    end
    out_ready[u] = 1'b1;
    @(negedge clk);
    chk1({tag, " idle valid"}, out_valid[u], 1'b0);
    chk1({tag, " idle busy"}, busy[u], 1'b0);
    chk1({tag, " idle in_ready"}, in_ready[u], 1'b1);
  endtask

  task automatic wait_idx(input int u, input int idx, input string tag);
    int k;
    k = 0;
    while (!(rk_rd_en[u] === 1'b1 && rk_idx[u] === 4'(idx)) && k < 40) begin @(negedge clk); k++; end
    chki({tag, " reach idx"}, int'(rk_idx[u]), idx);
  endtask

  initial begin
    logic [127:0] pt, pa, pb, ct;
    int           k, n, t0;
    logic         seen_a;

    rst = 1'b1;
    for (int u = 0; u < NU; u++) begin
      in_valid[u]  = 1'b0;
      in_data[u]   = '0;
      out_ready[u] = 1'b1;
`ifdef INV_CIPHER_CTRL_ABORT_EN
      abort_s[u]   = 1'b0;
`endif
    end
    for (int x = 0; x < 256; x++) sbox[x] = sb_calc(8'(x));

    repeat (2) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      in_valid[u] = 1'b1;
      #1;
      chk1("reset in_ready", in_ready[u], 1'b0);
      chk1("reset busy", busy[u], 1'b0);
      chk1("reset out_valid", out_valid[u], 1'b0);
      chk1("reset rd_en", rk_rd_en[u], 1'b0);
      chki("reset rk_idx", int'(rk_idx[u]), 0);
      chkw("reset out_data", out_data[u], '0);
      in_valid[u] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("release in_ready", in_ready[0], 1'b1);
    chk1("release busy", busy[0], 1'b0);

    // Known-answer vectors
    load_keys(0, 4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    load_keys(1, 8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    @(negedge clk);
    idx_log.delete();
    xfer(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 0, "aes128");
    chki("rk_idx count", idx_log.size(), NR0 + 1);
    for (int i = 0; i < idx_log.size() && i <= NR0; i++)
      chki($sformatf("rk_idx seq %0d", i), idx_log[i], NR0 - i);
    xfer(1, 128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff, 0, "aes256");

    // Random keys and blocks with random back-pressure
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        load_keys(0, 4, {rnd128(), rnd128()});
        load_keys(1, 8, {rnd128(), rnd128()});
      end
      pt = rnd128();
      xfer(i % 2, encrypt(i % 2, pt), pt, int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    pt = rnd128();
    xfer(0, encrypt(0, pt), pt, 20, "backpressure");

    // Back-to-back with in_valid held high
    pa = rnd128();
    pb = rnd128();
    out_ready[0] = 1'b1;
    in_data[0]   = encrypt(0, pa);
    in_valid[0]  = 1'b1;
    k = 0;
    while (in_ready[0] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    t0 = cyc;
    @(negedge clk);
    in_data[0] = encrypt(0, pb);
    seen_a = 1'b0;
    k = 0;
    while (in_ready[0] !== 1'b1 && k < 60) begin
      if (out_valid[0] === 1'b1) begin
        chkw("b2b first data", out_data[0], pa);
        seen_a = 1'b1;
      end
      @(negedge clk);
      k++;
    end
    chk1("b2b first seen", seen_a, 1'b1);
    chki("b2b spacing", cyc - t0, NR0 + 3);
    @(negedge clk);
    in_valid[0] = 1'b0;
    k = 1;
    while (out_valid[0] !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    chki("b2b second latency", k, NR0 + 2);
    chkw("b2b second data", out_data[0], pb);
    @(negedge clk);

    // Reset in the middle of ROUND (counter = 5)
    pt = rnd128();
    out_ready[0] = 1'b1;
    start(0, encrypt(0, pt), "midrst");
    wait_idx(0, 4, "midrst");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("midrst busy", busy[0], 1'b0);
    chk1("midrst out_valid", out_valid[0], 1'b0);
    chk1("midrst rd_en", rk_rd_en[0], 1'b0);
    chk1("midrst in_ready", in_ready[0], 1'b1);
    chkw("midrst out_data", out_data[0], '0);
    n = 0;
    repeat (20) begin @(negedge clk); if (out_valid[0] === 1'b1) n++; end
    chki("midrst no output", n, 0);

    // rst and in_valid together: nothing accepted
    in_data[0]  = encrypt(0, pt);
    in_valid[0] = 1'b1;
    rst = 1'b1;
    #1;
    chk1("rst+valid in_ready", in_ready[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid[0] = 1'b0;
    #1;
    chk1("rst+valid busy", busy[0], 1'b0);
    @(negedge clk);
    xfer(0, encrypt(0, pt), pt, 1, "after rst");

`ifdef INV_CIPHER_CTRL_ABORT_EN
    pt = rnd128();
    start(0, encrypt(0, pt), "abort");
    wait_idx(0, 6, "abort");
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    chk1("abort busy", busy[0], 1'b0);
    chk1("abort out_valid", out_valid[0], 1'b0);
    chk1("abort rd_en", rk_rd_en[0], 1'b0);
    n = 0;
    repeat (20) begin @(negedge clk); if (out_valid[0] === 1'b1) n++; end
    chki("abort no output", n, 0);

    abort_s[0]  = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = encrypt(0, pt);
    #1;
    chk1("abort idle in_ready", in_ready[0], 1'b0);
    @(negedge clk);
    abort_s[0]  = 1'b0;
    in_valid[0] = 1'b0;
    chk1("abort idle busy", busy[0], 1'b0);

    start(0, encrypt(0, pt), "abort+rst");
    wait_idx(0, 6, "abort+rst");
    abort_s[0] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    rst = 1'b0;
    #1;
    chk1("abort+rst busy", busy[0], 1'b0);
    chkw("abort+rst out_data", out_data[0], '0);
    chk1("abort+rst in_ready", in_ready[0], 1'b1);
    @(negedge clk);
    xfer(0, encrypt(0, pt), pt, 0, "after abort");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inv_cipher_ctrl.md
Name: inv_cipher_ctrl

Overview:
- Iterative AES inverse-cipher sequencer: owns the 128-bit state register and runs one inverse round per clock through a combinational round core.
- Fetches round keys in reverse order (Nr down to 0) from an external synchronous round-key store.
- Sits between the ciphertext source and the plaintext sink, with valid/ready handshakes on both sides.

Parameters:
- Nk, 4, key length in 32-bit words; legal values 4, 6, 8.
- Nr, 10, round count; must equal Nk+6 (10/12/14).
- IDXW, 4, width of the round-key index; must satisfy 2^IDXW > Nr.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  ciphertext valid
- in_ready  output  1  controller can accept ciphertext
- in_data  input  128  ciphertext block
- rk_rd_en  output  1  round-key read strobe
- rk_idx  output  IDXW  round-key index (0..Nr)
- rk_data  input  128  round key; valid exactly 1 cycle after rk_rd_en
- out_valid  output  1  plaintext valid
- out_ready  input  1  sink accepts plaintext
- out_data  output  128  plaintext block
- busy  output  1  high in any state other than IDLE

Behaviour:
- One clock. Reset is synchronous and active-high: clk and rst only, no asynchronous path.
- Reset values: FSM=IDLE, state register=0, round counter=0, rk_idx=0, rk_rd_en=0, out_valid=0, busy=0.
- in_ready = (FSM==IDLE) && !rst.
- FSM states: IDLE, INIT, ROUND, FINAL, DONE.
- IDLE
  - On in_valid && in_ready: latch in_data into the state register.
  - Drive rk_rd_en=1 and rk_idx=Nr.
  - Go to INIT.
- INIT (1 cycle)
  - state <= state ^ rk_data (key Nr).
  - Issue rk_idx=Nr-1; load the round counter with Nr-1.
  - Go to ROUND.
- ROUND (Nr-1 cycles)
  - state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_data)).
  - Decrement the counter; issue rk_idx=counter-1.
  - On the cycle with counter==1, go to FINAL (rk_idx=0 issued on that cycle).
- FINAL (1 cycle)
  - state <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_data).
  - rk_rd_en=0. Go to DONE.
- DONE
  - out_valid=1 and out_data=state, both held stable until out_ready.
  - On out_valid && out_ready, go to IDLE next cycle; out_valid deasserts.
- Timing
  - rk_rd_en is high on the IDLE accept cycle, in INIT, and in every ROUND cycle; low elsewhere.
  - Latency: out_valid rises exactly Nr+2 cycles after the input handshake cycle (12 / 14 / 16).
  - Throughput: one block per Nr+3 cycles minimum (with out_ready held high).
  - No new block is accepted while busy; in_valid is ignored outside IDLE.
- Boundaries
  - Back-pressure in DONE stalls indefinitely with no state change.
  - out_ready outside DONE is ignored.
  - rst asserted in any state: next cycle FSM=IDLE, outputs at reset values, and the in-flight block is dropped with no partial output.
  - rst and in_valid in the same cycle: rst wins; nothing is accepted.
- Arithmetic: all key mixing is 128-bit XOR. The counter width is IDXW bits and never wraps below 0.
- out_data equals the state register at all times; only out_valid qualifies it.

Optional Feature:
- Macro: INV_CIPHER_CTRL_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort high in INIT, ROUND, FINAL or DONE: next cycle FSM=IDLE, rk_rd_en=0, out_valid=0; the state register is not cleared.
  - abort in IDLE suppresses acceptance that cycle (in_ready gated low).
  - rst has priority over abort.
- Undefined: no abort port; the behaviour is exactly as above.

Decomposition:
- Shared package aes_pkg
  - FSM state enum.
  - Constants NR_AES128=10, NR_AES192=12, NR_AES256=14.
  - Function nr_of(Nk) returning Nk+6.
  - BLOCK_W=128.
- Sub-module inv_round_core (combinational)
  - Inputs: state, round key, final flag.
  - Built from the existing inverse shift-rows, inverse sub-bytes, add-round-key and inverse mix-columns blocks.
  - final=1 bypasses InvMixColumns.
  - INIT uses a plain XOR in the controller, not the core.

Test Plan:
- AES-128 (Nk=4, Nr=10), round-key store loaded from key 000102030405060708090a0b0c0d0e0f:
  - Input: in_data=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Expect: out_data=00112233445566778899aabbccddeeff with out_valid exactly 12 cycles after the handshake.
  - Expect: rk_idx sequence 10,9,...,0.
- AES-256 (Nk=8, Nr=14), key 00..1f:
  - Input: in_data=8ea2b7ca516745bfeafc49904b496089.
  - Expect: same plaintext, latency 16.
- Back-pressure: hold out_ready=0 for 20 cycles in DONE.
  - Expect: out_valid and out_data stable, in_ready=0, busy=1.
  - Release out_ready: IDLE the next cycle.
- Back-to-back: in_valid held high for two blocks.
  - Expect: second accepted the cycle after the first output handshake (Nr+3 spacing); both results correct.
- Mid-operation reset: pulse rst in ROUND at counter=5.
  - Expect: next cycle busy=0, out_valid=0, rk_rd_en=0, in_ready=1.
  - A fresh block then decrypts correctly.
- With INV_CIPHER_CTRL_ABORT_EN: abort in ROUND.
  - Expect: IDLE next cycle, no out_valid pulse.
  - abort and rst together: reset values.
